// File: rtl/pipe_demux_1x2_pkg.sv
// pipe_demux_1x2_pkg: shared widths for the 1-to-2 pipelined demultiplexer.
package pipe_demux_1x2_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
endpackage

// File: rtl/pipe_demux_1x2_demux_channel.sv
// demux_channel: one-entry output register with valid bit and wrapping transfer counter.
module demux_channel
    import pipe_demux_1x2_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic [N-1:0]     i_data,
    input  logic             i_ready,
    output logic [N-1:0]     o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);
    logic [N-1:0]     data_d, data_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             xfer;
    always_comb begin
        xfer    = valid_q & i_ready;
        data_d  = i_load ? i_data : data_q;
        // A load during a transfer refills the slot in the same cycle, so no bubble appears.
        valid_d = i_load | (valid_q & !xfer & !i_flush);
        count_d = count_q + CNT_W'(xfer);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end
    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_count = count_q;
endmodule

// File: rtl/pipe_demux_1x2.sv
// pipe_demux_1x2: routes a valid/ready source word to one of two registered output channels.
module pipe_demux_1x2
    import pipe_demux_1x2_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_data,
    input  logic             i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    output logic [N-1:0]     o_data0,
    output logic [N-1:0]     o_data1,
    output logic             o_valid0,
    output logic             o_valid1,
    input  logic             i_ready0,
    input  logic             i_ready1,
    output logic [CNT_W-1:0] o_count0,
    output logic [CNT_W-1:0] o_count1
);
    logic accept;
    always_comb begin
        o_ready = (i_sel ? (!o_valid1 | i_ready1) : (!o_valid0 | i_ready0)) & !i_flush;
        accept  = i_valid & o_ready;
    end
    demux_channel #(.N(N)) u_ch0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_load  (accept & !i_sel),
        .i_data  (i_data),
        .i_ready (i_ready0),
        .o_data  (o_data0),
        .o_valid (o_valid0),
        .o_count (o_count0)
    );
    demux_channel #(.N(N)) u_ch1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_load  (accept & i_sel),
        .i_data  (i_data),
        .i_ready (i_ready1),
        .o_data  (o_data1),
        .o_valid (o_valid1),
        .o_count (o_count1)
    );
endmodule

// File: tb/tb_pipe_demux_1x2.sv
// tb_pipe_demux_1x2: table-driven directed check of the 1-to-2 demux plus counter wrap sequence.
module tb_pipe_demux_1x2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic        r0 = 1'b0;
    logic        r1 = 1'b0;
    logic        ready;
    logic [15:0] d0, d1;
    logic        v0, v1;
    logic [7:0]  c0, c1;
    int total = 0;
    int bad = 0;

    typedef struct {
        int rst, s, val, fl, rd0, rd1, dat;
        int rdy, ev0, ev1, ed0, ed1, ec0, ec1;
    } vec_t;
    vec_t tv[18];

    always #5 clk = ~clk;

    pipe_demux_1x2 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_sel(sel), .i_valid(valid),
        .o_ready(ready), .i_flush(flush), .o_data0(d0), .o_data1(d1),
        .o_valid0(v0), .o_valid1(v1), .i_ready0(r0), .i_ready1(r1),
        .o_count0(c0), .o_count1(c1)
    );

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input int rst, input int s, input int val, input int fl,
                         input int rd0, input int rd1, input int dat);
        rst_n = 1'(rst);
        sel   = 1'(s);
        valid = 1'(val);
        flush = 1'(fl);
        r0    = 1'(rd0);
        r1    = 1'(rd1);
        data  = 16'(dat);
    endtask

    initial begin
        //        rst s val fl r0 r1 data     rdy v0 v1 d0       d1       c0 c1
        tv[0]  = '{0, 0, 0, 1, 0, 0, 'h0,     0, 0, 0, 'h0,    'h0,    0, 0};
        tv[1]  = '{1, 0, 1, 0, 1, 0, 'h1234,  1, 1, 0, 'h1234, 'h0,    0, 0};
        tv[2]  = '{1, 0, 0, 0, 1, 0, 'h0,     1, 0, 0, 'h1234, 'h0,    1, 0};
        tv[3]  = '{1, 1, 1, 0, 0, 0, 'hAAAA,  1, 0, 1, 'h1234, 'hAAAA, 1, 0};
        tv[4]  = '{1, 1, 1, 0, 0, 0, 'hBBBB,  0, 0, 1, 'h1234, 'hAAAA, 1, 0};
        tv[5]  = '{1, 0, 1, 0, 0, 0, 'hCCCC,  1, 1, 1, 'hCCCC, 'hAAAA, 1, 0};
        tv[6]  = '{1, 0, 1, 1, 0, 0, 'hDDDD,  0, 0, 0, 'hCCCC, 'hAAAA, 1, 0};
        tv[7]  = '{1, 1, 1, 0, 0, 1, 'h0001,  1, 0, 1, 'hCCCC, 'h0001, 1, 0};
        tv[8]  = '{1, 1, 1, 0, 0, 1, 'h0002,  1, 0, 1, 'hCCCC, 'h0002, 1, 1};
        tv[9]  = '{1, 1, 1, 0, 0, 1, 'h0003,  1, 0, 1, 'hCCCC, 'h0003, 1, 2};
        tv[10] = '{1, 1, 1, 0, 0, 1, 'h0004,  1, 0, 1, 'hCCCC, 'h0004, 1, 3};
        tv[11] = '{1, 1, 0, 0, 0, 1, 'h0,     1, 0, 0, 'hCCCC, 'h0004, 1, 4};
        tv[12] = '{1, 0, 1, 0, 0, 0, 'h5555,  1, 1, 0, 'h5555, 'h0004, 1, 4};
        tv[13] = '{1, 1, 1, 0, 0, 0, 'h6666,  1, 1, 1, 'h5555, 'h6666, 1, 4};
        tv[14] = '{1, 0, 0, 1, 1, 1, 'h0,     0, 0, 0, 'h5555, 'h6666, 2, 5};
        tv[15] = '{1, 1, 1, 0, 0, 0, 'h7777,  1, 0, 1, 'h5555, 'h7777, 2, 5};
        tv[16] = '{0, 1, 0, 0, 0, 1, 'h0,     1, 0, 0, 'h0,    'h0,    0, 0};
        tv[17] = '{1, 0, 0, 0, 0, 0, 'h0,     1, 0, 0, 'h0,    'h0,    0, 0};
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].s, tv[i].val, tv[i].fl, tv[i].rd0, tv[i].rd1, tv[i].dat);
            #1 chk($sformatf("v%0d o_ready", i), int'(ready), tv[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d o_valid0", i), int'(v0), tv[i].ev0);
            chk($sformatf("v%0d o_valid1", i), int'(v1), tv[i].ev1);
            chk($sformatf("v%0d o_data0", i), int'(d0), tv[i].ed0);
            chk($sformatf("v%0d o_data1", i), int'(d1), tv[i].ed1);
            chk($sformatf("v%0d o_count0", i), int'(c0), tv[i].ec0);
            chk($sformatf("v%0d o_count1", i), int'(c1), tv[i].ec1);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            drive(1, 0, 1, 0, 1, 0, i);
            #1 chk($sformatf("wrap%0d o_ready", i), int'(ready), 1);
        end
        @(posedge clk);
        #1;
        chk("wrap o_count0 pre", int'(c0), 255);
        chk("wrap o_data0 last", int'(d0), 255);
        chk("wrap o_valid1 idle", int'(v1), 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("wrap o_count0", int'(c0), 0);
        chk("wrap o_valid0 drained", int'(v0), 0);
        chk("wrap o_count1 untouched", int'(c1), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
